// File: rtl/sigmoid_sched_pkg.sv
// Shared types and constants for the sigmoid request scheduler.
// Holds the scheduler state encoding, Q16.16 reference constants and the
// width helper used for grant/pointer/counter sizing.
package sigmoid_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Q16.16 reference points of the sigmoid output range
    localparam logic [31:0] SIG_ONE  = 32'h0001_0000;
    localparam logic [31:0] SIG_HALF = 32'h0000_8000;

    // Ceiling log2 with a floor of 1 so single-entry ranges still get a bit
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sigmoid_sched_rr_pick.sv
// Combinational round-robin selector.
// Returns the index of the first asserted request at or above ptr,
// wrapping modulo NREQ, plus a flag telling whether any request is set.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] grant,
    output logic             any_req
);

    // Scan from the farthest position back toward ptr so the nearest set bit wins
    always_comb begin
        logic [PTR_W-1:0] idx;
        grant   = '0;
        any_req = |req;
        idx     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/sigmoid_sched.sv
// Scheduler sharing one piecewise-linear sigmoid core between NREQ lanes.
// One transaction at a time: round-robin accept, start pulse to the core,
// wait for its done pulse, then hold the result until the granted lane
// takes it. The result word is forwarded untouched.
// Optional feature: define SIG_TIMEOUT_EN to bound the core wait to TIMEOUT
// cycles; on expiry the lane receives 0.5 flagged by rsp_err.
module sigmoid_sched
    import sigmoid_sched_pkg::*;
#(
    parameter int N       = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_x,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [N-1:0]      rsp_data,
    output logic              rsp_err,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [N-1:0]      core_x,
    output logic              core_start,
    input  logic [N-1:0]      core_out,
    input  logic              core_done,
    output logic              busy
);

    localparam int PTR_W = clog2(NREQ);
    localparam int CNT_W = clog2(TIMEOUT);

    state_t                  state;
    logic [PTR_W-1:0]        rr_ptr;
    logic [PTR_W-1:0]        gnt_q;
    logic [PTR_W-1:0]        pick_idx;
    logic [PTR_W-1:0]        next_ptr;
    logic                    any_req;
    logic signed [N-1:0]     x_sel;
    logic [N-1:0]            x_arr [NREQ];

`ifdef SIG_TIMEOUT_EN
    localparam logic [N-1:0] HALF_Q = N'(1) << (N / 2 - 1);
    logic [CNT_W-1:0]        wait_cnt;
    logic                    rsp_err_q;
    assign rsp_err = rsp_err_q;
`else
    logic [CNT_W-1:0]        unused_timeout_w;
    assign unused_timeout_w = CNT_W'(TIMEOUT - 1);
    assign rsp_err          = 1'b0;
`endif

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .grant   (pick_idx),
        .any_req (any_req)
    );

    // Unpack the flat operand bus so the grant index can select a lane directly
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            x_arr[i] = req_x[i*N +: N];
        end
    end

    // Operand of the lane that would win this cycle, and the pointer after it
    always_comb begin
        x_sel    = x_arr[pick_idx];
        next_ptr = (pick_idx == PTR_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
    end

    // Accept pulse: only in IDLE, only to the single winning lane
    always_comb begin
        req_ready = '0;
        if (state == IDLE && any_req) begin
            req_ready = NREQ'(1) << pick_idx;
        end
    end

    assign busy = (state != IDLE);

    // Transaction sequencer: accept, start the core, wait for done, hand back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gnt_q      <= '0;
            core_x     <= '0;
            core_start <= 1'b0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
`ifdef SIG_TIMEOUT_EN
            wait_cnt   <= '0;
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_q      <= pick_idx;
                        core_x     <= x_sel;
                        rr_ptr     <= next_ptr;
                        core_start <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef SIG_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        rsp_data  <= core_out;
                        rsp_valid <= NREQ'(1) << gnt_q;
`ifdef SIG_TIMEOUT_EN
                        rsp_err_q <= 1'b0;
`endif
                        state     <= RESP;
                    end
`ifdef SIG_TIMEOUT_EN
                    // A core that never answers gets a neutral 0.5 substitute
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_data  <= HALF_Q;
                        rsp_valid <= NREQ'(1) << gnt_q;
                        rsp_err_q <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready[gnt_q]) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
